// File: rtl/sdrd_fat32_packbuf_if.sv
// Bus between the SD sector reader / FAT parser and the pack buffer.
// The writer drives WR/INPUT/FLUSH, the reader drives RD, and the buffer returns data and status.
interface sdrd_fat32_packbuf_if #(
  parameter int IN_W  = 256,
  parameter int RATIO = 2,
  parameter int DEPTH = 128
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  WR;
  logic [IN_W-1:0]       INPUT;
  logic                  FLUSH;
  logic                  RD;
  logic [IN_W*RATIO-1:0] OUTPUT;
  logic                  VALID;
  logic                  EMPTY;
  logic                  FULL;
  logic                  ALMOST_FULL;
  logic [CW-1:0]         COUNT;
  logic                  OVERFLOW;
  logic                  UNDERFLOW;

  modport master (
    output WR, INPUT, FLUSH, RD,
    input  OUTPUT, VALID, EMPTY, FULL, ALMOST_FULL, COUNT, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  WR, INPUT, FLUSH, RD,
    output OUTPUT, VALID, EMPTY, FULL, ALMOST_FULL, COUNT, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/sdrd_fat32_packbuf.sv
// Packs RATIO narrow FAT32 beats into one wide word and queues the words in a
// DEPTH-entry FIFO with a registered read port, partial-word flush, occupancy
// count, almost-full level and sticky overflow/underflow flags.
module sdrd_fat32_packbuf #(
  parameter int IN_W     = 256,
  parameter int RATIO    = 2,
  parameter int DEPTH    = 128,
  parameter int AF_LEVEL = 96
) (
  input  logic                 CLK,
  input  logic                 RSTS,
  sdrd_fat32_packbuf_if.slave  bus
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_pack_cnt;
  logic [OUT_W-1:0] r_pack;
  logic [CW-1:0]    r_count;
  logic             r_flush_pend;
  logic             r_empty;
  logic             r_full;
  logic             r_af;
  logic             r_ovf;
  logic             r_unf;
  logic             r_valid;
  logic [OUT_W-1:0] r_out;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_last;
  logic             w_do_flush;
  logic             w_commit;
  logic [OUT_W-1:0] w_word;
  logic [CW-1:0]    w_cnt_nxt;

  // FULL/EMPTY are registered, so a same-cycle read never frees room for a write
  // and a same-cycle commit never makes data readable.
  assign w_wr_acc   = bus.WR & ~r_full;
  assign w_rd_acc   = bus.RD & ~r_empty;
  assign w_last     = w_wr_acc & (r_pack_cnt == PW'(RATIO - 1));
  // A flush raised while full waits in r_flush_pend until room appears.
  assign w_do_flush = (bus.FLUSH | r_flush_pend) & ~r_full;
  assign w_commit   = w_last | (w_do_flush & ((r_pack_cnt != '0) | w_wr_acc));
  assign w_cnt_nxt  = r_count + CW'(w_commit) - CW'(w_rd_acc);

  // Word to commit: the pack register (unfilled slices are kept zero) plus this cycle's beat.
  always_comb begin
    w_word = r_pack;
    for (int i = 0; i < RATIO; i++) begin
      if (w_wr_acc && (r_pack_cnt == PW'(i))) begin
        w_word[i*IN_W +: IN_W] = bus.INPUT;
      end
    end
  end

  // Packing state and flush-pending flag; the pack register is cleared on every commit.
  always_ff @(posedge CLK or negedge RSTS) begin
    if (!RSTS) begin
      r_pack       <= '0;
      r_pack_cnt   <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_commit) begin
        r_pack     <= '0;
        r_pack_cnt <= '0;
      end else if (w_wr_acc) begin
        r_pack     <= w_word;
        r_pack_cnt <= r_pack_cnt + PW'(1);
      end
      if (bus.FLUSH && r_full) begin
        r_flush_pend <= 1'b1;
      end else if (!r_full) begin
        r_flush_pend <= 1'b0;
      end
    end
  end

  // Word storage; contents are don't-care after reset.
  always_ff @(posedge CLK) begin
    if (w_commit) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // Pointers, occupancy and the status flags derived from the next occupancy.
  always_ff @(posedge CLK or negedge RSTS) begin
    if (!RSTS) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_af     <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_commit) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
      r_af    <= (int'(w_cnt_nxt) >= AF_LEVEL);
      r_ovf   <= r_ovf | (bus.WR & r_full);
      r_unf   <= r_unf | (bus.RD & r_empty);
    end
  end

  // Registered read port: one cycle from an accepted RD to VALID/OUTPUT.
  always_ff @(posedge CLK or negedge RSTS) begin
    if (!RSTS) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (w_rd_acc) r_out <= r_mem[r_rd_ptr];
    end
  end

  assign bus.OUTPUT      = r_out;
  assign bus.VALID       = r_valid;
  assign bus.EMPTY       = r_empty;
  assign bus.FULL        = r_full;
  assign bus.ALMOST_FULL = r_af;
  assign bus.COUNT       = r_count;
  assign bus.OVERFLOW    = r_ovf;
  assign bus.UNDERFLOW   = r_unf;
endmodule

// File: tb/tb_sdrd_fat32_packbuf.sv
// Bench for sdrd_fat32_packbuf: a default-size instance for basic packing, plus
// two small instances (RATIO=2 and RATIO=4, DEPTH=4, AF_LEVEL=3) driven from
// vector tables and short hand-written sequences.
module tb_sdrd_fat32_packbuf;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  sdrd_fat32_packbuf_if #(.IN_W(256), .RATIO(2), .DEPTH(128)) bus_a ();
  sdrd_fat32_packbuf_if #(.IN_W(8),   .RATIO(2), .DEPTH(4))   bus_b ();
  sdrd_fat32_packbuf_if #(.IN_W(8),   .RATIO(4), .DEPTH(4))   bus_c ();

  sdrd_fat32_packbuf #(.IN_W(256), .RATIO(2), .DEPTH(128), .AF_LEVEL(96)) dut_a (
    .CLK(clk), .RSTS(rst_n), .bus(bus_a));
  sdrd_fat32_packbuf #(.IN_W(8), .RATIO(2), .DEPTH(4), .AF_LEVEL(3)) dut_b (
    .CLK(clk), .RSTS(rst_n), .bus(bus_b));
  sdrd_fat32_packbuf #(.IN_W(8), .RATIO(4), .DEPTH(4), .AF_LEVEL(3)) dut_c (
    .CLK(clk), .RSTS(rst_n), .bus(bus_c));

  // f = {FULL, EMPTY, ALMOST_FULL, OVERFLOW, UNDERFLOW}
  typedef struct {
    logic        wr;
    logic [7:0]  din;
    logic        fl;
    logic        rd;
    logic        vld;
    logic [31:0] out;
    int          cnt;
    logic [4:0]  f;
  } vec_t;

  vec_t tv_b[$];
  vec_t tv_c[$];

  function automatic vec_t v(logic wr, logic [7:0] din, logic fl, logic rd,
                             logic vld, logic [31:0] out, int cnt, logic [4:0] f);
    vec_t t;
    t.wr = wr; t.din = din; t.fl = fl; t.rd = rd;
    t.vld = vld; t.out = out; t.cnt = cnt; t.f = f;
    return t;
  endfunction

  function automatic logic [45:0] ev(vec_t t);
    return {t.vld, t.out, 8'(t.cnt), t.f};
  endfunction

  function automatic logic [45:0] act_b();
    return {bus_b.VALID, 16'h0, bus_b.OUTPUT, 5'h0, bus_b.COUNT, bus_b.FULL, bus_b.EMPTY,
            bus_b.ALMOST_FULL, bus_b.OVERFLOW, bus_b.UNDERFLOW};
  endfunction

  function automatic logic [45:0] act_c();
    return {bus_c.VALID, bus_c.OUTPUT, 5'h0, bus_c.COUNT, bus_c.FULL, bus_c.EMPTY,
            bus_c.ALMOST_FULL, bus_c.OVERFLOW, bus_c.UNDERFLOW};
  endfunction

  task automatic chk(input string nm, input logic [527:0] act, input logic [527:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic apply_b(input vec_t t, input string nm);
    @(negedge clk);
    bus_b.WR = t.wr; bus_b.INPUT = t.din; bus_b.FLUSH = t.fl; bus_b.RD = t.rd;
    @(posedge clk); #1;
    chk(nm, act_b(), ev(t));
  endtask

  task automatic apply_c(input vec_t t, input string nm);
    @(negedge clk);
    bus_c.WR = t.wr; bus_c.INPUT = t.din; bus_c.FLUSH = t.fl; bus_c.RD = t.rd;
    @(posedge clk); #1;
    chk(nm, act_c(), ev(t));
  endtask

  initial begin
    logic [255:0] da;
    logic [255:0] db;

    bus_a.WR = 0; bus_a.INPUT = '0; bus_a.FLUSH = 0; bus_a.RD = 0;
    bus_b.WR = 0; bus_b.INPUT = '0; bus_b.FLUSH = 0; bus_b.RD = 0;
    bus_c.WR = 0; bus_c.INPUT = '0; bus_c.FLUSH = 0; bus_c.RD = 0;

    // RATIO=2, DEPTH=4: underflow, fill, overflow, read at full, boundaries, wrap
    tv_b.push_back(v(0, 8'h00, 0, 1, 0, 32'h0000, 0, 5'b01001));
    tv_b.push_back(v(1, 8'h01, 0, 0, 0, 32'h0000, 0, 5'b01001));
    tv_b.push_back(v(1, 8'h02, 0, 0, 0, 32'h0000, 1, 5'b00001));
    tv_b.push_back(v(1, 8'h03, 0, 0, 0, 32'h0000, 1, 5'b00001));
    tv_b.push_back(v(1, 8'h04, 0, 0, 0, 32'h0000, 2, 5'b00001));
    tv_b.push_back(v(1, 8'h05, 0, 0, 0, 32'h0000, 2, 5'b00001));
    tv_b.push_back(v(1, 8'h06, 0, 0, 0, 32'h0000, 3, 5'b00101));
    tv_b.push_back(v(1, 8'h07, 0, 0, 0, 32'h0000, 3, 5'b00101));
    tv_b.push_back(v(1, 8'h08, 0, 0, 0, 32'h0000, 4, 5'b10101));
    tv_b.push_back(v(1, 8'h09, 0, 0, 0, 32'h0000, 4, 5'b10111));
    tv_b.push_back(v(1, 8'h0A, 0, 1, 1, 32'h0201, 3, 5'b00111));
    tv_b.push_back(v(0, 8'h00, 0, 0, 0, 32'h0201, 3, 5'b00111));
    tv_b.push_back(v(1, 8'h0B, 0, 0, 0, 32'h0201, 3, 5'b00111));
    tv_b.push_back(v(1, 8'h0C, 0, 0, 0, 32'h0201, 4, 5'b10111));
    tv_b.push_back(v(0, 8'h00, 0, 1, 1, 32'h0403, 3, 5'b00111));
    tv_b.push_back(v(0, 8'h00, 0, 1, 1, 32'h0605, 2, 5'b00011));
    tv_b.push_back(v(0, 8'h00, 0, 1, 1, 32'h0807, 1, 5'b00011));
    tv_b.push_back(v(0, 8'h00, 0, 1, 1, 32'h0C0B, 0, 5'b01011));
    tv_b.push_back(v(0, 8'h00, 0, 1, 0, 32'h0C0B, 0, 5'b01011));
    tv_b.push_back(v(1, 8'h0D, 0, 0, 0, 32'h0C0B, 0, 5'b01011));
    tv_b.push_back(v(1, 8'h0E, 0, 1, 0, 32'h0C0B, 1, 5'b00011));
    tv_b.push_back(v(1, 8'h0F, 0, 1, 1, 32'h0E0D, 0, 5'b01011));
    tv_b.push_back(v(1, 8'h10, 0, 1, 0, 32'h0E0D, 1, 5'b00011));
    tv_b.push_back(v(1, 8'h11, 0, 1, 1, 32'h100F, 0, 5'b01011));
    tv_b.push_back(v(1, 8'h12, 0, 0, 0, 32'h100F, 1, 5'b00011));
    tv_b.push_back(v(1, 8'h13, 0, 0, 0, 32'h100F, 1, 5'b00011));
    tv_b.push_back(v(1, 8'h14, 0, 1, 1, 32'h1211, 1, 5'b00011));
    tv_b.push_back(v(0, 8'h00, 0, 1, 1, 32'h1413, 0, 5'b01011));

    // RATIO=4, DEPTH=4: flush variants, flush while full, pending flush release
    tv_c.push_back(v(1, 8'h11, 0, 0, 0, 32'h00000000, 0, 5'b01000));
    tv_c.push_back(v(1, 8'h22, 0, 0, 0, 32'h00000000, 0, 5'b01000));
    tv_c.push_back(v(0, 8'h00, 1, 0, 0, 32'h00000000, 1, 5'b00000));
    tv_c.push_back(v(0, 8'h00, 0, 1, 1, 32'h00002211, 0, 5'b01000));
    tv_c.push_back(v(0, 8'h00, 1, 0, 0, 32'h00002211, 0, 5'b01000));
    tv_c.push_back(v(1, 8'h11, 0, 0, 0, 32'h00002211, 0, 5'b01000));
    tv_c.push_back(v(1, 8'h22, 0, 0, 0, 32'h00002211, 0, 5'b01000));
    tv_c.push_back(v(1, 8'h33, 1, 0, 0, 32'h00002211, 1, 5'b00000));
    tv_c.push_back(v(0, 8'h00, 0, 1, 1, 32'h00332211, 0, 5'b01000));
    tv_c.push_back(v(1, 8'h44, 1, 0, 0, 32'h00332211, 1, 5'b00000));
    tv_c.push_back(v(1, 8'h01, 0, 0, 0, 32'h00332211, 1, 5'b00000));
    tv_c.push_back(v(1, 8'h02, 0, 0, 0, 32'h00332211, 1, 5'b00000));
    tv_c.push_back(v(1, 8'h03, 0, 0, 0, 32'h00332211, 1, 5'b00000));
    tv_c.push_back(v(1, 8'h04, 0, 0, 0, 32'h00332211, 2, 5'b00000));
    tv_c.push_back(v(1, 8'h55, 1, 0, 0, 32'h00332211, 3, 5'b00100));
    tv_c.push_back(v(1, 8'h66, 1, 0, 0, 32'h00332211, 4, 5'b10100));
    tv_c.push_back(v(1, 8'h77, 0, 0, 0, 32'h00332211, 4, 5'b10110));
    tv_c.push_back(v(0, 8'h00, 1, 0, 0, 32'h00332211, 4, 5'b10110));
    tv_c.push_back(v(1, 8'h88, 0, 0, 0, 32'h00332211, 4, 5'b10110));
    tv_c.push_back(v(0, 8'h00, 0, 1, 1, 32'h00000044, 3, 5'b00110));
    tv_c.push_back(v(1, 8'h99, 0, 0, 0, 32'h00000044, 4, 5'b10110));
    tv_c.push_back(v(0, 8'h00, 0, 1, 1, 32'h04030201, 3, 5'b00110));
    tv_c.push_back(v(0, 8'h00, 0, 1, 1, 32'h00000055, 2, 5'b00010));
    tv_c.push_back(v(0, 8'h00, 0, 1, 1, 32'h00000066, 1, 5'b00010));
    tv_c.push_back(v(0, 8'h00, 0, 1, 1, 32'h00000099, 0, 5'b01010));
    tv_c.push_back(v(1, 8'hAA, 0, 0, 0, 32'h00000099, 0, 5'b01010));
    tv_c.push_back(v(0, 8'h00, 1, 0, 0, 32'h00000099, 1, 5'b00010));
    tv_c.push_back(v(0, 8'h00, 0, 1, 1, 32'h000000AA, 0, 5'b01010));

    // Reset state
    #3 rst_n = 1'b0;
    #10;
    chk("A_reset", {bus_a.VALID, bus_a.EMPTY, bus_a.FULL, bus_a.ALMOST_FULL, bus_a.OVERFLOW,
                    bus_a.UNDERFLOW, bus_a.COUNT, bus_a.OUTPUT}, {6'b010000, 8'd0, 512'd0});
    chk("B_reset", act_b(), {1'b0, 32'h0, 8'd0, 5'b01000});
    chk("C_reset", act_c(), {1'b0, 32'h0, 8'd0, 5'b01000});
    @(negedge clk);
    rst_n = 1'b1;

    // Default-size instance: two beats packed LSB-first into one word
    for (int i = 0; i < 8; i++) begin
      da[32*i +: 32] = $urandom;
      db[32*i +: 32] = $urandom;
    end
    @(negedge clk); bus_a.WR = 1'b1; bus_a.INPUT = da;
    @(posedge clk); #1;
    chk("A_beat0", {bus_a.VALID, bus_a.EMPTY, bus_a.COUNT}, {1'b0, 1'b1, 8'd0});
    @(negedge clk); bus_a.INPUT = db;
    @(posedge clk); #1;
    chk("A_beat1", {bus_a.VALID, bus_a.EMPTY, bus_a.COUNT}, {1'b0, 1'b0, 8'd1});
    @(negedge clk); bus_a.WR = 1'b0; bus_a.RD = 1'b1;
    @(posedge clk); #1;
    chk("A_read", {bus_a.VALID, bus_a.EMPTY, bus_a.COUNT, bus_a.OUTPUT},
        {1'b1, 1'b1, 8'd0, db, da});
    @(negedge clk); bus_a.RD = 1'b0;
    @(posedge clk); #1;
    chk("A_hold", {bus_a.VALID, bus_a.EMPTY, bus_a.COUNT, bus_a.OUTPUT},
        {1'b0, 1'b1, 8'd0, db, da});

    foreach (tv_b[i]) apply_b(tv_b[i], $sformatf("B[%0d]", i));
    foreach (tv_c[i]) apply_c(tv_c[i], $sformatf("C[%0d]", i));
    @(negedge clk);
    bus_c.WR = 0; bus_c.FLUSH = 0; bus_c.RD = 0;

    // Reset with two words stored and one beat half-packed
    apply_b(v(1, 8'h15, 0, 0, 0, 32'h1413, 0, 5'b01011), "R_w0");
    apply_b(v(1, 8'h16, 0, 0, 0, 32'h1413, 1, 5'b00011), "R_w1");
    apply_b(v(1, 8'h17, 0, 0, 0, 32'h1413, 1, 5'b00011), "R_w2");
    apply_b(v(1, 8'h18, 0, 0, 0, 32'h1413, 2, 5'b00011), "R_w3");
    apply_b(v(1, 8'h19, 0, 0, 0, 32'h1413, 2, 5'b00011), "R_w4");
    @(negedge clk);
    bus_b.WR = 0; bus_b.RD = 0; bus_b.FLUSH = 0;
    #2 rst_n = 1'b0;
    #1 chk("R_async", act_b(), {1'b0, 32'h0, 8'd0, 5'b01000});
    @(negedge clk);
    rst_n = 1'b1;
    apply_b(v(1, 8'h21, 0, 0, 0, 32'h0000, 0, 5'b01000), "R_p0");
    apply_b(v(1, 8'h22, 0, 0, 0, 32'h0000, 1, 5'b00000), "R_p1");
    apply_b(v(0, 8'h00, 0, 1, 1, 32'h2221, 0, 5'b01000), "R_rd");
    @(negedge clk);
    bus_b.WR = 0; bus_b.RD = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdrd_fat32_packbuf.md
Name: sdrd_fat32_packbuf

Overview:
Parametrised successor to the SD-read FAT32 buffer. Packs RATIO narrow FAT32 input beats into one wide output word and stores the words in an internal DEPTH-entry FIFO. Adds a partial-word flush, an occupancy count, an almost-full level and sticky error flags. Sits between the SD sector reader, which writes 256-bit beats, and the FAT/cluster-chain parser, which reads 512-bit words.

Parameters:
IN_W, 256, input beat width in bits
RATIO, 2, input beats per output word; output width OUT_W = IN_W*RATIO; legal range 1..8
DEPTH, 128, FIFO depth in output words; must be a power of 2 and at least 2
AF_LEVEL, 96, ALMOST_FULL asserts when COUNT >= AF_LEVEL

Ports:
CLK  in  1  system clock; all logic is on the rising edge
RSTS  in  1  asynchronous active-low reset
WR  in  1  input beat strobe
INPUT  in  IN_W  input beat
FLUSH  in  1  single-cycle pulse: commit the partially packed word
RD  in  1  read strobe
OUTPUT  out  IN_W*RATIO  read data, registered
VALID  out  1  OUTPUT holds a freshly read word this cycle
EMPTY  out  1  no committed words stored
FULL  out  1  DEPTH committed words stored
ALMOST_FULL  out  1  COUNT >= AF_LEVEL
COUNT  out  clog2(DEPTH+1)  number of committed words
OVERFLOW  out  1  sticky: WR was presented while FULL
UNDERFLOW  out  1  sticky: RD was presented while EMPTY

Behaviour:
- Reset (RSTS=0, asynchronous): all pointers, pack_cnt, the pack register, COUNT and the flush-pending flag clear to 0. Output values during reset: OUTPUT=0, VALID=0, EMPTY=1, FULL=0, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0. RAM contents are don't-care. A reset in the middle of packing discards the partial word.
- Packing:
  - pack_cnt runs 0..RATIO-1.
  - An accepted beat (WR=1 and FULL=0) is written into slice pack_cnt of the pack register. Beat 0 goes in bits [IN_W-1:0], so the first beat lands in the LSBs.
  - When the beat fills slice RATIO-1, the assembled word is committed to RAM at wr_ptr in the same cycle. wr_ptr then increments and pack_cnt returns to 0.
- Write while FULL: the beat is dropped, pack state is unchanged, and OVERFLOW is set.
- FULL, EMPTY, COUNT and ALMOST_FULL:
  - All four are registered and reflect committed words only.
  - Beats still in the pack register are not counted and are not readable.
- Flush:
  - FLUSH with pack_cnt>0 commits the pack register with unfilled slices zeroed, then sets pack_cnt=0.
  - If WR is accepted in the same cycle as FLUSH, that beat is included before the commit.
  - FLUSH with pack_cnt=0 and no accepted WR is a no-op.
  - FLUSH while FULL sets the flush-pending flag. The commit happens in the first cycle FULL=0, and WR beats arriving meanwhile are dropped as overflow.
- Read:
  - RD=1 with EMPTY=0 reads RAM[rd_ptr] and increments rd_ptr.
  - OUTPUT updates and VALID=1 on the next cycle (1-cycle latency).
  - Otherwise VALID=0 and OUTPUT holds its last value.
  - RD while EMPTY is ignored and sets UNDERFLOW.
- COUNT updates each cycle:
  - a commit alone: +1
  - a read alone: -1
  - a commit and a read in the same cycle: unchanged
- Full/empty boundaries:
  - When FULL, a same-cycle RD is honoured but WR is still rejected, because the FULL flag is registered.
  - When EMPTY, a same-cycle commit is stored but RD is still rejected.
- Pointers: wr_ptr and rd_ptr are clog2(DEPTH)-bit and wrap naturally from DEPTH-1 to 0.
- Sticky flags: OVERFLOW and UNDERFLOW clear only on reset.
- RATIO=1 degenerates to a plain registered-output FIFO: each accepted beat commits immediately.

Test Plan:
- Basic pack (defaults): WR beats A then B (IN_W=256), then RD → VALID one cycle after RD, OUTPUT = {B,A}; COUNT goes 0→1→0 and EMPTY returns to 1.
- Flush (RATIO=4, IN_W=8): WR 0x11 and 0x22, then FLUSH → COUNT=1; RD returns 0x00002211. A same-cycle WR 0x33 with FLUSH instead gives 0x00332211.
- Fill/overflow (DEPTH=4, RATIO=2): write 8 beats → FULL=1, COUNT=4. A 9th WR → OVERFLOW=1 and COUNT stays 4. Reading 4 words returns the written data in order, then EMPTY=1.
- Simultaneous traffic at full (DEPTH=4): with FULL=1, assert RD together with the beat completing a word → read honoured, write dropped, COUNT=3, OVERFLOW=1.
- Underflow plus flags: RD while EMPTY → VALID stays 0 and UNDERFLOW=1. With AF_LEVEL=3, DEPTH=4: ALMOST_FULL rises on the commit that makes COUNT=3.
- Reset mid-operation: assert RSTS=0 after 1 of 2 beats and with 2 words stored → all outputs immediately at reset values. After release, the first 2 beats written are read back as one word with no stale data.
